pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It detects load-use hazards between ID and EX, resolves taken branches, and freezes the pipeline while data memory is busy. It drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A timeout watchdog halts the pipeline on a hung memory access, and a saturating counter accumulates stall cycles for performance monitoring.

## Interface
- LU_CYCLES, 1: bubble cycles inserted per load-use hazard; legal range 1..7.
- MEM_TIMEOUT, 64: consecutive freeze cycles that trigger a halt; legal range 2..255.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_rs1, id_rs2  in  3  source register numbers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the ID instruction actually reads rs1 / rs2.
- ex_mem_read  in  1  the instruction in EX is a load (ID/EX MEM_read field).
- ex_rd  in  3  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC write enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register write enables.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load zero into all ID/EX control fields.
- halted  out  1  pipeline halted by timeout.
- mem_timeout  out  1  sticky timeout error flag.
- stall_cycles  out  16  saturating count of front-end stall cycles.
- state  out  2  FSM state: RUN=0, LU_STALL=1, HALT=2.

## Operation
Derived terms:
- lu = ex_mem_read & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2)).
- freeze = mem_req & ~mem_ready.

Each cycle's outputs follow the first matching rule below. Outputs are combinational from state and inputs.
- rst high: all enables 0, if_id_flush=0, id_ex_bubble=0.
- HALT: all enables 0, flush/bubble 0, halted=1.
- freeze (any other state): all five enables 0, flush/bubble 0. State, lu_cnt and stall_cycles hold; wait_cnt increments.
- RUN & ex_branch_taken: all enables 1, if_id_flush=1, id_ex_bubble=1. Any load-use hazard in this cycle is ignored.
- RUN & lu: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1, mem_wb_en=1. If LU_CYCLES>1, go to LU_STALL with lu_cnt=LU_CYCLES-1.
- LU_STALL: same outputs as RUN & lu; lu_cnt decrements. When lu_cnt==1 at the clock edge, go to RUN. ex_branch_taken is ignored in this state.
- RUN otherwise: all enables 1, flush/bubble 0.

Counters:
- wait_cnt (8 bit): clears on any non-freeze cycle. If freeze is active and wait_cnt==MEM_TIMEOUT-1 at the edge, go to HALT and set mem_timeout=1. The pipeline therefore halts after MEM_TIMEOUT consecutive freeze cycles.
- stall_cycles: increments on each cycle with pc_en=0, excluding freeze, HALT and reset cycles. Saturates at 0xFFFF.
- HALT is left only through rst.

## Timing
- Reset values: state=RUN, lu_cnt=0, wait_cnt=0, stall_cycles=0, mem_timeout=0, halted=0.
- Reset is asynchronous, so asserting it mid-stall or mid-freeze forces the reset values immediately. The first cycle after release is RUN.
- Hazard response has zero latency: controls are valid in the same cycle the inputs are presented.
- A load-use hazard costs exactly LU_CYCLES front-end stall cycles, plus any interleaved freeze cycles.
- Freeze is transparent to the stall sequence: a LU_STALL interrupted by freeze resumes with lu_cnt unchanged.
- Priority, highest first: rst > HALT > freeze > branch > load-use.

## Test plan
- Reset mid-LU_STALL (LU_CYCLES=3, rst pulse on 2nd stall cycle) -> all enables 0 during rst; state=0, stall_cycles=0 after release; next cycle all enables 1.
- LU_CYCLES=1; ex_mem_read=1, ex_rd=3, id_rs2=3, id_rs2_used=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle (ex_mem_read=0) all enables 1; stall_cycles=1.
- LU_CYCLES=3, same hazard -> three consecutive bubble cycles, state sequence 0,1,1,0; stall_cycles=3. With id_rs2_used=0 the same inputs give no stall.
- ex_branch_taken=1 and lu=1 in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1, state stays 0, stall_cycles unchanged.
- LU_CYCLES=3; freeze (mem_req=1, mem_ready=0) for 2 cycles after the 1st bubble -> 2 cycles with all enables 0, then 2 more bubble cycles; stall_cycles=3.
- MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> 4 freeze cycles, then halted=1, mem_timeout=1, state=2. Deasserting mem_req keeps the halt; rst clears it.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Detects ID/EX load-use hazards, flushes on taken branches, freezes the whole
// pipeline while data memory is busy, halts on a hung memory access and keeps
// a saturating count of front-end stall cycles.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   id_rs1/id_rs2, *_used    ID source registers and their use flags
//   ex_mem_read, ex_rd       EX load flag and destination register
//   ex_branch_taken          branch resolved taken in EX
//   mem_req, mem_ready       data memory handshake
//   pc_en, *_en              PC and pipeline register write enables
//   if_id_flush, id_ex_bubble  NOP/bubble injection
//   halted, mem_timeout      halt status and sticky timeout flag
//   stall_cycles             saturating front-end stall counter
//   state                    RUN=0, LU_STALL=1, HALT=2
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_CYCLES   = 1,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  id_rs1,
  input  logic [2:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        halted,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [1:0]  state
);

  localparam int unsigned LU_W    = 3;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned STALL_W = 16;
  localparam bit          MULTI_LU = (LU_CYCLES > 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_HALT     = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LU_W-1:0]      r_lu_cnt;
  logic [LU_W-1:0]      w_lu_cnt_nxt;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [STALL_W-1:0]   r_stall_cycles;
  logic                 r_mem_timeout;
  logic                 w_lu;
  logic                 w_freeze;
  logic                 w_freeze_act;
  logic                 w_timeout_hit;

  assign w_lu = ex_mem_read & ((id_rs1_used & (ex_rd == id_rs1)) |
                               (id_rs2_used & (ex_rd == id_rs2)));
  assign w_freeze      = mem_req & ~mem_ready;
  // Freeze only matters outside HALT; HALT already owns the pipeline.
  assign w_freeze_act  = w_freeze & (r_state != S_HALT);
  assign w_timeout_hit = w_freeze_act & (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  assign state        = r_state;
  assign mem_timeout  = r_mem_timeout;
  assign stall_cycles = r_stall_cycles;

  // State register and load-use bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_lu_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
    end
  end

  // Next state: freeze holds everything; a hazard in RUN opens the stall window.
  always_comb begin
    w_state_nxt  = r_state;
    w_lu_cnt_nxt = r_lu_cnt;
    if (r_state != S_HALT) begin
      if (w_freeze) begin
        if (w_timeout_hit) w_state_nxt = S_HALT;
      end else if (r_state == S_LU_STALL) begin
        w_lu_cnt_nxt = r_lu_cnt - LU_W'(1);
        if (r_lu_cnt == LU_W'(1)) w_state_nxt = S_RUN;
      end else if (!ex_branch_taken && w_lu && MULTI_LU) begin
        w_state_nxt  = S_LU_STALL;
        w_lu_cnt_nxt = LU_W'(LU_CYCLES - 1);
      end
    end
  end

  // Output decode in priority order: rst, HALT, freeze, branch, load-use.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    if (!rst) begin
      if (r_state == S_HALT) begin
        halted = 1'b1;
      end else if (!w_freeze) begin
        if (r_state == S_LU_STALL || (!ex_branch_taken && w_lu)) begin
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          if_id_flush  = ex_branch_taken;
          id_ex_bubble = ex_branch_taken;
        end
      end
    end
  end

  // Freeze watchdog, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_wait_cnt <= w_freeze_act ? (r_wait_cnt + WAIT_W'(1)) : '0;
      if (w_timeout_hit) r_mem_timeout <= 1'b1;
      if (!pc_en && (r_state != S_HALT) && !w_freeze && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + STALL_W'(1);
    end
  end

endmodule
